// File: rtl/status_reg_int.sv
// ----------------------------------------------------------------------------
// status_reg_int
//   6502 processor status register (P) and interrupt request front end for
//   the 2A03 core. Takes ALU flag results, hands C back to the ALU, executes
//   the flag set/clear ops, PLP/PHP, BIT updates, and detects NMI edges and
//   IRQ levels for the control FSM. D is storage only (no decimal mode).
//
//   Optional build macro: INT_SYNC_EN -- adds a 2-flop synchronizer (reset
//   to 1) on nmi_n/irq_n ahead of the sample flop. Detection latency from
//   pin to int_pending goes from 2 to 4 clocks.
//
// Ports
//   clk, reset_n                  core clock, async active-low reset
//   alu_carry/overflow/zero/sign  ALU flag results
//   upd_nz, upd_c, upd_v          load N,Z / C / V from the ALU
//   bit_op                        BIT: N,V from data_in[7:6], Z from alu_zero
//   plp, data_in                  load P from data bus (bits 5:4 discarded)
//   flag_op_vld, flag_op          CLC,SEC,CLI,SEI,CLV,CLD,SED,no-op
//   int_entry                     interrupt/BRK entry: set I
//   brk                           B bit value presented on push_data[4]
//   int_ack                       FSM has taken the interrupt vector
//   nmi_n, irq_n                  interrupt lines, active low
//   carry_in                      current C to the ALU
//   status                        {N,V,1,1,D,I,Z,C}
//   push_data                     {N,V,1,brk,D,I,Z,C} for stack pushes
//   int_pending, int_is_nmi       registered interrupt request / NMI flag
// ----------------------------------------------------------------------------
module status_reg_int #(
   parameter logic [7:0] RESET_FLAGS = 8'h04
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       alu_carry,
   input  logic       alu_overflow,
   input  logic       alu_zero,
   input  logic       alu_sign,
   input  logic       upd_nz,
   input  logic       upd_c,
   input  logic       upd_v,
   input  logic       bit_op,
   input  logic       plp,
   input  logic [7:0] data_in,
   input  logic       flag_op_vld,
   input  logic [2:0] flag_op,
   input  logic       int_entry,
   input  logic       brk,
   input  logic       int_ack,
   input  logic       nmi_n,
   input  logic       irq_n,
   output logic       carry_in,
   output logic [7:0] status,
   output logic [7:0] push_data,
   output logic       int_pending,
   output logic       int_is_nmi
);

   localparam int FN = 7, FV = 6, FD = 3, FI = 2, FZ = 1, FC = 0;
   // Bits 5:4 read as 1 in P, so keep them set in storage as well.
   localparam logic [7:0] P_RST = RESET_FLAGS | 8'h30;

   logic [7:0] p_q, p_d;
   logic       nmi_s_q, nmi_s_d;
   logic       nmi_prev_q, nmi_prev_d;
   logic       irq_s_q, irq_s_d;
   logic       nmi_latch_q, nmi_latch_d;
   logic       int_pending_q, int_pending_d;
   logic       int_is_nmi_q, int_is_nmi_d;
   logic       nmi_raw, irq_raw;
   logic       nmi_fall, irq_req;

`ifdef INT_SYNC_EN
   logic [1:0] nmi_sync_q, nmi_sync_d;
   logic [1:0] irq_sync_q, irq_sync_d;

   always_comb begin
      nmi_sync_d = {nmi_sync_q[0], nmi_n};
      irq_sync_d = {irq_sync_q[0], irq_n};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nmi_sync_q <= 2'b11;
         irq_sync_q <= 2'b11;
      end else begin
         nmi_sync_q <= nmi_sync_d;
         irq_sync_q <= irq_sync_d;
      end
   end

   assign nmi_raw = nmi_sync_q[1];
   assign irq_raw = irq_sync_q[1];
`else
   assign nmi_raw = nmi_n;
   assign irq_raw = irq_n;
`endif

   // Flag writes: later assignments override earlier ones, so sources are
   // applied lowest priority first (upd_* < bit_op < flag_op < int_entry).
   always_comb begin
      p_d = p_q;
      if (plp) begin
         p_d = data_in | 8'h30;
      end else begin
         if (upd_nz) begin
            p_d[FN] = alu_sign;
            p_d[FZ] = alu_zero;
         end
         if (upd_c) p_d[FC] = alu_carry;
         if (upd_v) p_d[FV] = alu_overflow;
         if (bit_op) begin
            p_d[FN] = data_in[7];
            p_d[FV] = data_in[6];
            p_d[FZ] = alu_zero;
         end
         if (flag_op_vld) begin
            case (flag_op)
               3'd0:    p_d[FC] = 1'b0;
               3'd1:    p_d[FC] = 1'b1;
               3'd2:    p_d[FI] = 1'b0;
               3'd3:    p_d[FI] = 1'b1;
               3'd4:    p_d[FV] = 1'b0;
               3'd5:    p_d[FD] = 1'b0;
               3'd6:    p_d[FD] = 1'b1;
               default: ;
            endcase
         end
         if (int_entry) p_d[FI] = 1'b1;
      end
   end

   // Interrupt detection. The latch next-state feeds int_pending directly so
   // an NMI edge reaches the output one clock after it is sampled.
   always_comb begin
      nmi_s_d    = nmi_raw;
      irq_s_d    = irq_raw;
      nmi_prev_d = nmi_s_q;
      nmi_fall   = nmi_prev_q & ~nmi_s_q;
      // Ack clears only an NMI being serviced; a fresh edge in that same
      // cycle keeps the latch set.
      nmi_latch_d   = nmi_fall | (nmi_latch_q & ~(int_ack & int_is_nmi_q));
      irq_req       = ~irq_s_q & ~p_q[FI];
      int_pending_d = nmi_latch_d | irq_req;
      int_is_nmi_d  = nmi_latch_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p_q           <= P_RST;
         nmi_s_q       <= 1'b1;
         nmi_prev_q    <= 1'b1;
         irq_s_q       <= 1'b1;
         nmi_latch_q   <= 1'b0;
         int_pending_q <= 1'b0;
         int_is_nmi_q  <= 1'b0;
      end else begin
         p_q           <= p_d;
         nmi_s_q       <= nmi_s_d;
         nmi_prev_q    <= nmi_prev_d;
         irq_s_q       <= irq_s_d;
         nmi_latch_q   <= nmi_latch_d;
         int_pending_q <= int_pending_d;
         int_is_nmi_q  <= int_is_nmi_d;
      end
   end

   assign carry_in    = p_q[FC];
   assign status      = p_q;
   assign push_data   = {p_q[7:6], 1'b1, brk, p_q[3:0]};
   assign int_pending = int_pending_q;
   assign int_is_nmi  = int_is_nmi_q;

endmodule

// File: tb/tb_status_reg_int.sv
module tb_status_reg_int;

`ifdef INT_SYNC_EN
   localparam int D = 3;
`else
   localparam int D = 1;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       alu_carry = 0, alu_overflow = 0, alu_zero = 0, alu_sign = 0;
   logic       upd_nz = 0, upd_c = 0, upd_v = 0, bit_op = 0, plp = 0;
   logic [7:0] data_in = 8'h00;
   logic       flag_op_vld = 0;
   logic [2:0] flag_op = 3'd7;
   logic       int_entry = 0, brk = 0, int_ack = 0;
   logic       nmi_n = 1'b1, irq_n = 1'b1;
   logic       carry_in, int_pending, int_is_nmi;
   logic [7:0] status, push_data;

   int checks = 0;
   int errors = 0;

   status_reg_int dut (
      .clk(clk), .reset_n(reset_n),
      .alu_carry(alu_carry), .alu_overflow(alu_overflow),
      .alu_zero(alu_zero), .alu_sign(alu_sign),
      .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v),
      .bit_op(bit_op), .plp(plp), .data_in(data_in),
      .flag_op_vld(flag_op_vld), .flag_op(flag_op),
      .int_entry(int_entry), .brk(brk), .int_ack(int_ack),
      .nmi_n(nmi_n), .irq_n(irq_n),
      .carry_in(carry_in), .status(status), .push_data(push_data),
      .int_pending(int_pending), .int_is_nmi(int_is_nmi)
   );

   always #5 clk = ~clk;

   // Reference model: individual flags plus line history (index k = level
   // presented k clocks before the most recent edge).
   bit mN, mV, mD, mI, mZ, mC;
   bit mlatch, mpend, misnmi;
   bit nh[$];
   bit ih[$];

   function automatic logic [7:0] m_status();
      return {mN, mV, 2'b11, mD, mI, mZ, mC};
   endfunction

   task automatic model_reset();
      {mN, mV, mD, mI, mZ, mC} = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      mlatch = 0; mpend = 0; misnmi = 0;
      nh.delete(); ih.delete();
      for (int k = 0; k < 8; k++) begin
         nh.push_back(1'b1);
         ih.push_back(1'b1);
      end
   endtask

   task automatic model_edge();
      bit fall, irq_req, fv;
      nh.push_front(nmi_n);
      ih.push_front(irq_n);
      while (nh.size() > 8) void'(nh.pop_back());
      while (ih.size() > 8) void'(ih.pop_back());
      fall    = nh[D+1] && !nh[D];
      irq_req = !ih[D] && !mI;
      mlatch  = fall || (mlatch && !(int_ack && misnmi));
      mpend   = mlatch || irq_req;
      misnmi  = mlatch;
      fv = flag_op_vld;
      if (plp) begin
         {mN, mV} = data_in[7:6];
         {mD, mI, mZ, mC} = data_in[3:0];
      end else begin
         if (int_entry)                 mI = 1;
         else if (fv && flag_op == 2)   mI = 0;
         else if (fv && flag_op == 3)   mI = 1;
         if (fv && flag_op == 0)        mC = 0;
         else if (fv && flag_op == 1)   mC = 1;
         else if (upd_c)                mC = alu_carry;
         if (fv && flag_op == 4)        mV = 0;
         else if (bit_op)               mV = data_in[6];
         else if (upd_v)                mV = alu_overflow;
         if (fv && flag_op == 5)        mD = 0;
         else if (fv && flag_op == 6)   mD = 1;
         if (bit_op)                    mN = data_in[7];
         else if (upd_nz)               mN = alu_sign;
         if (bit_op)                    mZ = alu_zero;
         else if (upd_nz)               mZ = alu_zero;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".status"}, status, m_status());
      chk({tag, ".push"}, push_data, {mN, mV, 1'b1, brk, mD, mI, mZ, mC});
      chk({tag, ".carry"}, {7'd0, carry_in}, {7'd0, mC});
      chk({tag, ".pend"}, {7'd0, int_pending}, {7'd0, mpend});
      chk({tag, ".nmi"}, {7'd0, int_is_nmi}, {7'd0, misnmi});
   endtask

   // Inputs are driven after a negedge; outputs sampled at the next negedge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic clr();
      upd_nz = 0; upd_c = 0; upd_v = 0; bit_op = 0; plp = 0;
      flag_op_vld = 0; flag_op = 3'd7; int_entry = 0; int_ack = 0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      // Reset state
      chk("rst.status", status, 8'h34);
      chk("rst.push", push_data, 8'h24);
      chk("rst.carry", {7'd0, carry_in}, 8'h00);
      chk("rst.pend", {7'd0, int_pending}, 8'h00);
      reset_n = 1'b1;
      tick(); check_all("idle");

      // ALU flag loads
      upd_nz = 1; upd_c = 1; upd_v = 1;
      alu_sign = 1; alu_zero = 0; alu_carry = 1; alu_overflow = 1;
      tick(); clr();
      chk("alu.status", status, 8'hF5);
      chk("alu.carry", {7'd0, carry_in}, 8'h01);
      check_all("alu");

      // PLP then BIT
      plp = 1; data_in = 8'hCB;
      tick(); clr();
      chk("plp.status", status, 8'hFB);
      bit_op = 1; data_in = 8'h40; alu_zero = 1;
      tick(); clr();
      chk("bit.status", status, 8'h7B);
      check_all("bit");

      // Priority cases (I is 0 here)
      int_entry = 1; flag_op_vld = 1; flag_op = 3'd2;
      tick(); clr();
      chk("prio.I", {7'd0, status[2]}, 8'h01);
      flag_op_vld = 1; flag_op = 3'd1; upd_c = 1; alu_carry = 0;
      tick(); clr();
      chk("prio.C", {7'd0, carry_in}, 8'h01);
      bit_op = 1; upd_nz = 1; data_in = 8'h80; alu_sign = 0; alu_zero = 0;
      tick(); clr();
      chk("prio.N", {7'd0, status[7]}, 8'h01);
      flag_op_vld = 1; flag_op = 3'd7;
      tick(); clr();
      check_all("nop");
      flag_op_vld = 1; flag_op = 3'd6;
      tick(); clr();
      chk("sed.D", {7'd0, status[3]}, 8'h01);

      // NMI edge
      nmi_n = 0;
      for (int k = 0; k < D; k++) begin
         tick();
         chk("nmi.early", {7'd0, int_pending}, 8'h00);
      end
      tick();
      chk("nmi.pend", {7'd0, int_pending}, 8'h01);
      chk("nmi.isnmi", {7'd0, int_is_nmi}, 8'h01);
      repeat (3) begin tick(); check_all("nmi.hold"); end
      int_ack = 1;
      tick(); clr();
      chk("nmi.ack", {7'd0, int_pending}, 8'h00);
      for (int k = 0; k < 14; k++) begin
         tick();
         chk("nmi.noretrig", {7'd0, int_pending}, 8'h00);
      end
      nmi_n = 1;
      repeat (D + 1) tick();
      nmi_n = 0;
      repeat (D + 1) tick();
      chk("nmi.reedge", {7'd0, int_pending}, 8'h01);
      check_all("nmi.reedge");
      int_ack = 1;
      tick(); clr();
      check_all("nmi.ack2");
      nmi_n = 1;

      // IRQ level (I is 1)
      irq_n = 0;
      repeat (D + 2) tick();
      chk("irq.masked", {7'd0, int_pending}, 8'h00);
      flag_op_vld = 1; flag_op = 3'd2;
      tick(); clr();
      check_all("irq.cli");
      tick();
      chk("irq.pend", {7'd0, int_pending}, 8'h01);
      chk("irq.notnmi", {7'd0, int_is_nmi}, 8'h00);
      irq_n = 1;
      repeat (D + 1) tick();
      chk("irq.drop", {7'd0, int_pending}, 8'h00);
      irq_n = 0;
      repeat (D + 1) tick();
      chk("irq.again", {7'd0, int_pending}, 8'h01);
      #2 reset_n = 0;
      #1;
      model_reset();
      chk("arst.pend", {7'd0, int_pending}, 8'h00);
      chk("arst.status", status, 8'h34);
      irq_n = 1;
      @(negedge clk);
      reset_n = 1;
      tick(); check_all("post.rst");

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         plp         = ($urandom_range(15) == 0);
         bit_op      = ($urandom_range(7) == 0);
         upd_nz      = $urandom_range(1);
         upd_c       = $urandom_range(1);
         upd_v       = $urandom_range(1);
         flag_op_vld = ($urandom_range(3) == 0);
         flag_op     = 3'($urandom_range(7));
         int_entry   = ($urandom_range(15) == 0);
         int_ack     = ($urandom_range(5) == 0);
         brk         = $urandom_range(1);
         data_in     = 8'($urandom);
         {alu_carry, alu_overflow, alu_zero, alu_sign} = 4'($urandom);
         if ($urandom_range(5) == 0) nmi_n = ~nmi_n;
         if ($urandom_range(7) == 0) irq_n = ~irq_n;
         tick();
         check_all("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
